// File: rtl/dffram_pkg.sv
// dffram_pkg: shared clear-FSM state type and byte-lane helper for dffram_1rw1r
package dffram_pkg;
  typedef enum logic [0:0] {CLEAR = 1'b0, READY = 1'b1} clr_state_e;
  function automatic int lanes(input int width);
    return width / 8;
  endfunction
endpackage

// File: rtl/dffram_1rw1r_if.sv
// dffram_1rw1r_if: port 0 read/write and port 1 read-only bus signals of the RAM
interface dffram_1rw1r_if
  import dffram_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int A_WIDTH = 7
);
  localparam int LANES = lanes(WIDTH);
  logic               EN0;
  logic [LANES-1:0]   WE0;
  logic [A_WIDTH-1:0] A0;
  logic [WIDTH-1:0]   Di0;
  logic [WIDTH-1:0]   Do0;
  logic               EN1;
  logic [A_WIDTH-1:0] A1;
  logic [WIDTH-1:0]   Do1;
  logic               BUSY;
  modport master (output EN0, WE0, A0, Di0, EN1, A1, input Do0, Do1, BUSY);
  modport slave (input EN0, WE0, A0, Di0, EN1, A1, output Do0, Do1, BUSY);
endinterface

// File: rtl/dffram_clear_fsm.sv
// dffram_clear_fsm: after reset, sweeps every word once writing zero, holding busy until done
module dffram_clear_fsm
  import dffram_pkg::*;
#(
  parameter int WORDS = 128,
  localparam int A_WIDTH = $clog2(WORDS)
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               busy,
  output logic [A_WIDTH-1:0] clr_addr,
  output logic               clr_we
);
  clr_state_e         state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  // advance the sweep address; leave CLEAR on the edge that clears the last word
  always_comb begin
    state_d = (state_q == CLEAR && cnt_q == A_WIDTH'(WORDS - 1)) ? READY : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end
  // any reset, even mid-sweep, restarts the full clear from word 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign busy     = state_q == CLEAR;
  assign clr_we   = busy;
  assign clr_addr = cnt_q;
endmodule

// File: rtl/dffram_1rw1r.sv
// dffram_1rw1r: flip-flop RAM, one read-first R/W port and one read port; DFFRAM_CLEAR_EN adds a post-reset clear
module dffram_1rw1r
  import dffram_pkg::*;
#(
  parameter int WORDS = 128,
  parameter int WIDTH = 32,
  localparam int A_WIDTH = $clog2(WORDS)
) (
  input logic           CLK,
  input logic           RST,
  dffram_1rw1r_if.slave bus
);
  localparam int LANES = lanes(WIDTH);
  localparam logic [A_WIDTH:0] LIMIT = (A_WIDTH + 1)'(WORDS);
  logic [WIDTH-1:0]   mem_q [WORDS];
  logic               busy, clr_we, en0, en1;
  logic [A_WIDTH-1:0] clr_addr, wr_addr;
  logic [LANES-1:0]   wr_be;
  logic [WIDTH-1:0]   wr_data, do0_d, do0_q, do1_d, do1_q;
`ifdef DFFRAM_CLEAR_EN
  dffram_clear_fsm #(.WORDS(WORDS)) u_clear (
    .CLK     (CLK),
    .RST     (RST),
    .busy    (busy),
    .clr_addr(clr_addr),
    .clr_we  (clr_we)
  );
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif
  // gate accesses by busy and range; the clear sweep owns the write port ahead of port 0
  always_comb begin
    en0     = bus.EN0 && !busy && ({1'b0, bus.A0} < LIMIT);
    en1     = bus.EN1 && !busy && ({1'b0, bus.A1} < LIMIT);
    wr_addr = clr_we ? clr_addr : bus.A0;
    wr_be   = clr_we ? '1 : (en0 ? bus.WE0 : '0);
    wr_data = clr_we ? '0 : bus.Di0;
    do0_d   = en0 ? mem_q[bus.A0] : '0;
    do1_d   = en1 ? mem_q[bus.A1] : '0;
  end
  // registered read data, zeroed at once by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      do0_q <= '0;
      do1_q <= '0;
    end else begin
      do0_q <= do0_d;
      do1_q <= do1_d;
    end
  end
  // byte-masked array write; reads above see the old word, so both ports are read-first
  always_ff @(posedge CLK) begin
    for (int i = 0; i < LANES; i++)
      if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
  end
  assign bus.Do0  = do0_q;
  assign bus.Do1  = do1_q;
  assign bus.BUSY = busy;
endmodule

// File: tb/tb_dffram_1rw1r.sv
// tb_dffram_1rw1r: directed scoreboard bench for dffram_1rw1r
module tb_dffram_1rw1r;
`ifdef DFFRAM_CLEAR_EN
  localparam bit CLR   = 1'b1;
  localparam int WORDS = 128;
`else
  localparam bit CLR   = 1'b0;
  localparam int WORDS = 100;
`endif
  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk0 = 1'b0, chk1 = 1'b0, v0, v1;
  int checks = 0, failures = 0, n;
  exp_t q0[$], q1[$];
  dffram_1rw1r_if #(.WIDTH(32), .A_WIDTH(7)) bus ();
  dffram_1rw1r #(.WORDS(WORDS), .WIDTH(32)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask
  task automatic step(input logic e0, input logic [3:0] w0, input int a0, input logic [31:0] d0,
                      input logic e1, input int a1, input logic c0, input logic [31:0] x0,
                      input logic c1, input logic [31:0] x1, input string nm);
    @(posedge clk);
    #1;
    bus.EN0 = e0; bus.WE0 = w0; bus.A0 = a0[6:0]; bus.Di0 = d0;
    bus.EN1 = e1; bus.A1 = a1[6:0];
    chk0 = c0; chk1 = c1;
    if (c0) q0.push_back('{nm, x0});
    if (c1) q1.push_back('{nm, x1});
  endtask
  task automatic busy_len(input string nm);
    n = 0;
    while (bus.BUSY && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, n, CLR ? WORDS : 0);
  endtask
  // read-valid tracker: one cycle behind an issued read, like the DUT's latency
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      v0 <= chk0;
      v1 <= chk1;
    end
  end
  // monitor: pop and compare whenever a tracked read is presented
  always @(negedge clk) begin
    exp_t e;
    if (v0) begin
      if (q0.size() == 0) chk("do0_unexpected", bus.Do0, 32'hx);
      else begin
        e = q0.pop_front();
        chk({e.nm, "_do0"}, bus.Do0, e.v);
      end
    end
    if (v1) begin
      if (q1.size() == 0) chk("do1_unexpected", bus.Do1, 32'hx);
      else begin
        e = q1.pop_front();
        chk({e.nm, "_do1"}, bus.Do1, e.v);
      end
    end
  end
  initial begin
    bus.EN0 = 0; bus.WE0 = 0; bus.A0 = 0; bus.Di0 = 0; bus.EN1 = 0; bus.A1 = 0;
    #3 rst = 1'b1;
    #4;
    chk("rst_do0", bus.Do0, 0);
    chk("rst_do1", bus.Do1, 0);
    chk("rst_busy", {31'b0, bus.BUSY}, {31'b0, CLR});
    @(posedge clk);
    #1 rst = 1'b0;
    busy_len("busy_len");
`ifndef DFFRAM_CLEAR_EN
    for (int i = 0; i < WORDS; i++) step(1, 4'hF, i, 0, 0, 0, 0, 0, 0, 0, "init");
`endif
    for (int i = 0; i < WORDS; i++) step(1, 0, i, 0, 1, i, 1, 0, 1, 0, "zero_rd");
    step(1, 4'hF, 5, 32'h11223344, 0, 0, 1, 0, 0, 0, "be_wr1");
    step(1, 4'b0101, 5, 32'hAABBCCDD, 0, 0, 1, 32'h11223344, 0, 0, "be_wr2");
    step(0, 0, 0, 0, 1, 5, 1, 0, 1, 32'h11BB33DD, "be_rd");
    step(1, 4'hF, 9, 32'hDEADBEEF, 1, 9, 1, 0, 1, 0, "coll");
    step(1, 0, 9, 0, 1, 9, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, "coll_after");
    step(0, 4'hF, 9, 0, 0, 0, 1, 0, 0, 0, "en0_low");
    step(0, 0, 0, 0, 1, 9, 1, 0, 1, 32'hDEADBEEF, "en0_low_unch");
`ifndef DFFRAM_CLEAR_EN
    step(1, 4'hF, 120, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, "oor_wr");
    step(1, 0, 120, 0, 1, 120, 1, 0, 1, 0, "oor_rd");
    step(1, 0, 20, 0, 1, 56, 1, 0, 1, 0, "oor_alias");
    step(1, 4'hF, 99, 32'hCAFEF00D, 0, 0, 1, 0, 0, 0, "w99");
    step(1, 0, 99, 0, 1, 99, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, "r99");
`endif
    step(1, 0, 9, 0, 1, 5, 1, 32'hDEADBEEF, 1, 32'h11BB33DD, "pre_rst");
    @(posedge clk);
    @(negedge clk);
    #1;
    chk0 = 0; chk1 = 0; rst = 1'b1;
    #1;
    chk("ready_rst_do0", bus.Do0, 0);
    chk("ready_rst_do1", bus.Do1, 0);
    chk("ready_rst_busy", {31'b0, bus.BUSY}, {31'b0, CLR});
    @(posedge clk);
    #1;
    rst = 1'b0; bus.EN0 = 0; bus.EN1 = 0;
`ifdef DFFRAM_CLEAR_EN
    repeat (60) @(posedge clk);
    #1;
    chk("mid_busy_pre", {31'b0, bus.BUSY}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, bus.BUSY}, 1);
    chk("mid_rst_do0", bus.Do0, 0);
    chk("mid_rst_do1", bus.Do1, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    busy_len("mid_busy_len");
    step(1, 0, 9, 0, 1, 5, 1, 0, 1, 0, "post_clr");
`else
    busy_len("nc_busy_len");
    step(1, 0, 9, 0, 1, 5, 1, 32'hDEADBEEF, 1, 32'h11BB33DD, "retain");
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    @(negedge clk);
    chk("drain", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
